// File: rtl/decoder7_pkg.sv
// decoder7_pkg: shared widths, types and reset value for the registered 3-to-8 decoder
package decoder7_pkg;
    localparam int SEL_W = 3;
    localparam int OUT_W = 8;
    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_W-1:0] dec_t;
    localparam dec_t DEC_RST_VAL = 8'h00;
endpackage

// File: rtl/decoder7_mux8_1.sv
// mux8_1: single-bit 8:1 mux selecting d[sel]
module mux8_1
    import decoder7_pkg::*;
(
    input  dec_t d,
    input  sel_t sel,
    output logic y
);
    assign y = d[sel];
endmodule

// File: rtl/decoder7.sv
// decoder7: registered one-hot decode of {A,B,C}, one mux per output bit
module decoder7
    import decoder7_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    output dec_t FINAL_OUT
);
    sel_t sel;
    dec_t dec;
    assign sel = {A, B, C};
    genvar n;
    generate
        for (n = 0; n < OUT_W; n++) begin : g_bit
            localparam dec_t D = dec_t'(1) << n;
            mux8_1 u_mux (.d(D), .sel(sel), .y(dec[n]));
        end
    endgenerate
    // register the decode; reset clears the word without waiting for clk
    always_ff @(posedge clk or posedge rst)
        if (rst) FINAL_OUT <= DEC_RST_VAL;
        else     FINAL_OUT <= dec;
endmodule

// File: tb/tb_decoder7.sv
// tb_decoder7: directed and randomized checks of decoder7 against a behavioural model
module tb_decoder7;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic A, B, C;
    logic [7:0] FINAL_OUT;
    int total = 0;
    int bad = 0;

    decoder7 dut (.clk(clk), .rst(rst), .A(A), .B(B), .C(C), .FINAL_OUT(FINAL_OUT));

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_dec(input logic [2:0] s);
        int idx;
        idx = 4 * int'(s[2]) + 2 * int'(s[1]) + int'(s[0]);
        return 8'(2 ** idx);
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [2:0] s, input string tag);
        {A, B, C} = s;
        @(posedge clk);
        @(negedge clk);
        chk(tag, FINAL_OUT, ref_dec(s));
        chk({tag, "_onehot"}, 8'($countones(FINAL_OUT)), 8'd1);
    endtask

    logic [2:0] sweep [7] = '{3'b001, 3'b010, 3'b011, 3'b000, 3'b100, 3'b101, 3'b110};
    logic [7:0] sweep_exp [7] = '{8'h02, 8'h04, 8'h08, 8'h01, 8'h10, 8'h20, 8'h40};
    logic [2:0] revisit [3] = '{3'b010, 3'b100, 3'b111};
    logic [7:0] revisit_exp [3] = '{8'h04, 8'h10, 8'h80};

    initial begin
        {A, B, C} = 3'b111;
        #1 rst = 1'b1;
        #1 chk("rst_immediate", FINAL_OUT, 8'h00);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_hold", FINAL_OUT, 8'h00);
        end
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(sweep[i], "sweep");
            chk("sweep_const", FINAL_OUT, sweep_exp[i]);
        end
        for (int i = 0; i < 3; i++) begin
            step(revisit[i], "revisit");
            chk("revisit_const", FINAL_OUT, revisit_exp[i]);
        end
        step(3'b000, "lat_base");
        #2 {A, B, C} = 3'b111;
        #1 chk("lat_hold", FINAL_OUT, 8'h01);
        @(posedge clk);
        @(negedge clk);
        chk("lat_update", FINAL_OUT, 8'h80);
        step(3'b101, "mid_pre");
        step(3'b101, "mid_repeat");
        #2 rst = 1'b1;
        #1 chk("mid_async", FINAL_OUT, 8'h00);
        @(posedge clk);
        @(negedge clk);
        chk("mid_hold", FINAL_OUT, 8'h00);
        rst = 1'b0;
        step(3'b101, "mid_release");
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(15) == 0) begin
                {A, B, C} = 3'($urandom);
                rst = 1'b1;
                #1 chk("rnd_rst", FINAL_OUT, 8'h00);
                @(posedge clk);
                @(negedge clk);
                chk("rnd_rst_hold", FINAL_OUT, 8'h00);
                rst = 1'b0;
            end else begin
                step(3'($urandom), "rnd");
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
